// File: rtl/game_loop_ctrl_if.sv
// Game loop controller bundle: player/painter/collision inputs and the
// registered game-state outputs. master drives the inputs, slave is the controller.
interface game_loop_ctrl_if #(
    parameter int FPS     = 60,
    parameter int SPEED_W = 15,
    parameter int LIVES   = 3
);
    logic                         jumping;
    logic                         pause_btn;
    logic                         painter_finished;
    logic                         crash_in;

    logic                         tick;
    logic [$clog2(FPS)-1:0]       timer;
    logic [SPEED_W-1:0]           speed;
    logic [2:0]                   state;
    logic                         start;
    logic                         restart;
    logic                         has_obstacles;
    logic [$clog2(LIVES+1)-1:0]   lives;
    logic                         invuln;

    modport master (
        output jumping, pause_btn, painter_finished, crash_in,
        input  tick, timer, speed, state, start, restart,
        input  has_obstacles, lives, invuln
    );

    modport slave (
        input  jumping, pause_btn, painter_finished, crash_in,
        output tick, timer, speed, state, start, restart,
        output has_obstacles, lives, invuln
    );
endinterface

// File: rtl/game_loop_ctrl.sv
// Game loop controller: frame ticks from the painter, game FSM, speed ramp,
// lives/immunity and obstacle-free start window.
// Ports: clk, rst_n (async, active low), bus (game_loop_ctrl_if.slave):
//   in  jumping, pause_btn, painter_finished, crash_in
//   out tick, timer, speed, state, start, restart, has_obstacles, lives, invuln
module game_loop_ctrl #(
    parameter int FPS           = 60,
    parameter int SPEED_W       = 15,
    parameter int SPEED_INIT    = 6144,
    parameter int MAX_SPEED     = 13312,
    parameter int ACCEL         = 1,
    parameter int CLEAR_FRAMES  = 180,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 120
) (
    input logic              clk,
    input logic              rst_n,
    game_loop_ctrl_if.slave  bus
);

    localparam int TW  = $clog2(FPS);
    localparam int LW  = $clog2(LIVES + 1);
    localparam int CW  = $clog2(CLEAR_FRAMES + 2);
    localparam int IW  = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int SW1 = SPEED_W + 1;

    localparam logic [TW-1:0]      TIMER_LAST = TW'(FPS - 1);
    localparam logic [CW-1:0]      CLR_LIM    = CW'(CLEAR_FRAMES);
    localparam logic [CW-1:0]      CLR_SAT    = CW'(CLEAR_FRAMES + 1);
    localparam logic [IW-1:0]      IMM_LOAD   = IW'(INVULN_FRAMES);
    localparam logic [LW-1:0]      LIVES_LOAD = LW'(LIVES);
    localparam logic [SW1-1:0]     MAX_EXT    = SW1'(MAX_SPEED);
    localparam logic [SW1-1:0]     ACCEL_EXT  = SW1'(ACCEL);
    localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPD_INIT   = SPEED_W'(SPEED_INIT);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSE   = 3'd2,
        S_CRASH   = 3'd3,
        S_RESTART = 3'd4
    } state_t;

    state_t             state_q, nxt_state;

    logic               pf_q, jump_q, pause_q;
    logic               tick_q, nxt_tick;
    logic [TW-1:0]      timer_q, nxt_timer;
    logic [SPEED_W-1:0] speed_q, nxt_speed;
    logic               start_q, nxt_start;
    logic               restart_q, nxt_restart;
    logic               obst_q, nxt_obst;
    logic [LW-1:0]      lives_q, nxt_lives;
    logic               invuln_q, nxt_invuln;
    logic [CW-1:0]      clear_q, nxt_clear;
    logic [IW-1:0]      imm_q, nxt_imm;

    logic               pf_rise, jump_rise, pause_rise;
    logic               step, crash_hit;
    logic [SW1-1:0]     speed_sum;
    logic [SPEED_W-1:0] speed_inc;
    logic [CW-1:0]      clear_inc;

    assign pf_rise    = bus.painter_finished & ~pf_q;
    assign jump_rise  = bus.jumping & ~jump_q;
    assign pause_rise = bus.pause_btn & ~pause_q;

    // A game step is a painter frame edge; nothing steps while paused.
    assign step      = pf_rise && (state_q != S_PAUSE);
    assign crash_hit = bus.crash_in && !invuln_q;

    // One extra bit keeps the add from wrapping before the ceiling compare.
    assign speed_sum = {1'b0, speed_q} + ACCEL_EXT;
    assign speed_inc = (speed_sum > MAX_EXT) ? SPD_MAX
                                             : speed_sum[SPEED_W-1:0];

    assign clear_inc = (clear_q == CLR_SAT) ? clear_q : clear_q + CW'(1);

    always_comb begin
        nxt_state  = state_q;
        nxt_tick   = step;
        nxt_timer  = timer_q;
        nxt_speed  = speed_q;
        nxt_start  = start_q;
        nxt_obst   = obst_q;
        nxt_lives  = lives_q;
        nxt_clear  = clear_q;
        nxt_imm    = imm_q;

        if (step) begin
            nxt_timer = (timer_q == TIMER_LAST) ? '0 : timer_q + TW'(1);
        end

        unique case (state_q)
            S_WAIT: begin
                if (step && bus.jumping) begin
                    nxt_state = S_RUN;
                    nxt_start = 1'b1;
                    nxt_speed = SPD_INIT;
                end
            end
            S_RUN: begin
                if (step && crash_hit) begin
                    if (lives_q <= LW'(1)) begin
                        nxt_state = S_CRASH;
                        nxt_lives = '0;
                    end else begin
                        nxt_lives = lives_q - LW'(1);
                        nxt_imm   = IMM_LOAD;
                        nxt_clear = clear_inc;
                        nxt_obst  = obst_q | (clear_inc > CLR_LIM);
                    end
                end else if (pause_rise) begin
                    nxt_state = S_PAUSE;
                end else if (step) begin
                    nxt_speed = speed_inc;
                    nxt_clear = clear_inc;
                    nxt_obst  = obst_q | (clear_inc > CLR_LIM);
                    if (imm_q != '0) begin
                        nxt_imm = imm_q - IW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (pause_rise) begin
                    nxt_state = S_RUN;
                end
            end
            S_CRASH: begin
                // Edge only, so a jump still held from play cannot restart.
                if (jump_rise) begin
                    nxt_state = S_RESTART;
                end
            end
            S_RESTART: begin
                if (!bus.jumping) begin
                    nxt_state = S_WAIT;
                    nxt_start = 1'b0;
                    nxt_speed = '0;
                    nxt_clear = '0;
                    nxt_obst  = 1'b0;
                    nxt_imm   = '0;
                    nxt_lives = LIVES_LOAD;
                end
            end
            default: begin
                nxt_state = S_WAIT;
            end
        endcase

        nxt_restart = (nxt_state == S_RESTART);
        nxt_invuln  = (nxt_imm != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= nxt_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_q      <= 1'b0;
            jump_q    <= 1'b0;
            pause_q   <= 1'b0;
            tick_q    <= 1'b0;
            timer_q   <= '0;
            speed_q   <= '0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            obst_q    <= 1'b0;
            lives_q   <= LIVES_LOAD;
            invuln_q  <= 1'b0;
            clear_q   <= '0;
            imm_q     <= '0;
        end else begin
            pf_q      <= bus.painter_finished;
            jump_q    <= bus.jumping;
            pause_q   <= bus.pause_btn;
            tick_q    <= nxt_tick;
            timer_q   <= nxt_timer;
            speed_q   <= nxt_speed;
            start_q   <= nxt_start;
            restart_q <= nxt_restart;
            obst_q    <= nxt_obst;
            lives_q   <= nxt_lives;
            invuln_q  <= nxt_invuln;
            clear_q   <= nxt_clear;
            imm_q     <= nxt_imm;
        end
    end

    assign bus.tick          = tick_q;
    assign bus.timer         = timer_q;
    assign bus.speed         = speed_q;
    assign bus.state         = state_q;
    assign bus.start         = start_q;
    assign bus.restart       = restart_q;
    assign bus.has_obstacles = obst_q;
    assign bus.lives         = lives_q;
    assign bus.invuln        = invuln_q;

endmodule
